// File: rtl/dual_port_ram_if.sv
// Bus bundle for the dual-port RAM: request and response signals of ports A and B,
// plus the write-collision flag. The master drives requests; the RAM is the slave.
interface dual_port_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    // Handshake: a request has no ready; the RAM accepts a read on every edge where
    // re_x is high, and rvalid_x is a one-cycle strobe marking the matching dout_x.
    logic                  we_a;
    logic [NUM_BYTES-1:0]  be_a;
    logic                  re_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  rvalid_a;

    logic                  we_b;
    logic [NUM_BYTES-1:0]  be_b;
    logic                  re_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  rvalid_b;

    logic                  collision;

    modport master (
        output we_a, be_a, re_a, addr_a, din_a,
        output we_b, be_b, re_b, addr_b, din_b,
        input  dout_a, rvalid_a, dout_b, rvalid_b, collision
    );

    modport slave (
        input  we_a, be_a, re_a, addr_a, din_a,
        input  we_b, be_b, re_b, addr_b, din_b,
        output dout_a, rvalid_a, dout_b, rvalid_b, collision
    );
endinterface

// File: rtl/dual_port_ram.sv
// Single-clock true dual-port RAM with byte-lane writes, selectable same-port
// read-during-write behaviour, optional output register and collision flag.
module dual_port_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_MODE    = 0,   // 0 read-first, 1 write-first, 2 no-change
    parameter int OUT_REG    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    dual_port_ram_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] merged_a, merged_b;
    logic [DATA_WIDTH-1:0] final_a;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
    logic                  rd_fire_a, rd_fire_b;
    logic                  same_addr, overlap;

    logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
    logic                  rvalid_a_q, rvalid_b_q;
    logic                  collision_q;

    // Merge write data per lane and decide what each port reads this cycle.
    always_comb begin
        old_a     = mem[bus.addr_a];
        old_b     = mem[bus.addr_b];
        merged_a  = old_a;
        merged_b  = old_b;
        final_a   = old_a;
        same_addr = (bus.addr_a == bus.addr_b);
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.be_a[i]) begin
                merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (bus.be_b[i]) begin
                merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            // Word written by A also carries B's lanes when both hit one address;
            // A's lanes override B's where they overlap.
            if (bus.be_a[i]) begin
                final_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (same_addr && bus.we_b && bus.be_b[i]) begin
                final_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        overlap   = bus.we_a && bus.we_b && same_addr && (|(bus.be_a & bus.be_b));
        // Only the port's own write is visible to its read; the other port's write
        // is never forwarded, so cross-port reads see the pre-write word.
        rd_fire_a = bus.re_a && !(RD_MODE == 2 && bus.we_a);
        rd_fire_b = bus.re_b && !(RD_MODE == 2 && bus.we_b);
        rd_word_a = (RD_MODE == 1 && bus.we_a) ? merged_a : old_a;
        rd_word_b = (RD_MODE == 1 && bus.we_b) ? merged_b : old_b;
    end

    // Array update; contents deliberately survive reset, writes are ignored during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else begin
            if (bus.we_b && (|bus.be_b)) begin
                mem[bus.addr_b] <= merged_b;
            end
            if (bus.we_a && (|bus.be_a)) begin
                mem[bus.addr_a] <= final_a;
            end
        end
    end

    // First read stage: capture read data and strobes, flag overlapping writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            rvalid_a_q  <= rd_fire_a;
            rvalid_b_q  <= rd_fire_b;
            collision_q <= overlap;
            if (rd_fire_a) begin
                dout_a_q <= rd_word_a;
            end
            if (rd_fire_b) begin
                dout_b_q <= rd_word_b;
            end
        end
    end

    assign bus.collision = collision_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_a_p, dout_b_p;
            logic                  rvalid_a_p, rvalid_b_p;

            // Output stage: free-running, data only moves when a read completes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_a_p   <= '0;
                    dout_b_p   <= '0;
                    rvalid_a_p <= 1'b0;
                    rvalid_b_p <= 1'b0;
                end else begin
                    rvalid_a_p <= rvalid_a_q;
                    rvalid_b_p <= rvalid_b_q;
                    if (rvalid_a_q) begin
                        dout_a_p <= dout_a_q;
                    end
                    if (rvalid_b_q) begin
                        dout_b_p <= dout_b_q;
                    end
                end
            end

            assign bus.dout_a   = dout_a_p;
            assign bus.dout_b   = dout_b_p;
            assign bus.rvalid_a = rvalid_a_p;
            assign bus.rvalid_b = rvalid_b_p;
        end else begin : g_no_out_reg
            assign bus.dout_a   = dout_a_q;
            assign bus.dout_b   = dout_b_q;
            assign bus.rvalid_a = rvalid_a_q;
            assign bus.rvalid_b = rvalid_b_q;
        end
    endgenerate
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram. Four instances share one stimulus stream:
// 0 read-first, 1 write-first, 2 no-change (all OUT_REG=0), 3 read-first with OUT_REG=1.
module tb_dual_port_ram;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 8;

    logic          clk;
    logic          rst_n;
    logic          we_a, re_a, we_b, re_b;
    logic [1:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    int n_assert;
    int n_fail;
    logic [DW-1:0] exp_q[$];

    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign bus[g].we_a   = we_a;
        assign bus[g].be_a   = be_a;
        assign bus[g].re_a   = re_a;
        assign bus[g].addr_a = addr_a;
        assign bus[g].din_a  = din_a;
        assign bus[g].we_b   = we_b;
        assign bus[g].be_b   = be_b;
        assign bus[g].re_b   = re_b;
        assign bus[g].addr_b = addr_b;
        assign bus[g].din_b  = din_b;

        dual_port_ram #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
            .RD_MODE((g == 3) ? 0 : g), .OUT_REG((g == 3) ? 1 : 0)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        we_a = 0; re_a = 0; be_a = 2'b00; addr_a = '0; din_a = '0;
        we_b = 0; re_b = 0; be_b = 2'b00; addr_b = '0; din_b = '0;
    endtask

    // One clock edge; outputs are examined 1 ns later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        we_a = 1; addr_a = a; din_a = d; be_a = be;
        cycle();
        clear_inputs();
    endtask

    task automatic read_a(input logic [AW-1:0] a);
        re_a = 1; addr_a = a;
        cycle();
        clear_inputs();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clear_inputs();
        rst_n = 0;
        repeat (3) cycle();
        check_eq("reset dout_a", bus[0].dout_a, 16'h0000);
        check_eq("reset rvalid_a", bus[0].rvalid_a, 1'b0);
        check_eq("reset collision", bus[0].collision, 1'b0);
        check_eq("reset outreg rvalid_b", bus[3].rvalid_b, 1'b0);
        rst_n = 1;
        cycle();

        // Write A, read back through B.
        write_a(4'd3, 16'hBEEF, 2'b11);
        re_b = 1; addr_b = 4'd3;
        cycle();
        clear_inputs();
        check_eq("b read rvalid", bus[0].rvalid_b, 1'b1);
        check_eq("b read data", bus[0].dout_b, 16'hBEEF);
        check_eq("outreg b not yet", bus[3].rvalid_b, 1'b0);
        cycle();
        check_eq("b rvalid pulse ends", bus[0].rvalid_b, 1'b0);
        check_eq("b dout holds", bus[0].dout_b, 16'hBEEF);
        check_eq("outreg b rvalid", bus[3].rvalid_b, 1'b1);
        check_eq("outreg b data", bus[3].dout_b, 16'hBEEF);

        // Partial byte write.
        write_a(4'd5, 16'h1234, 2'b11);
        write_a(4'd5, 16'hABCD, 2'b01);
        read_a(4'd5);
        check_eq("byte lane merge", bus[0].dout_a, 16'h12CD);

        // Same-port read during write.
        write_a(4'd7, 16'h1111, 2'b11);
        we_a = 1; re_a = 1; be_a = 2'b11; addr_a = 4'd7; din_a = 16'h2222;
        cycle();
        clear_inputs();
        check_eq("rdw read_first data", bus[0].dout_a, 16'h1111);
        check_eq("rdw read_first rvalid", bus[0].rvalid_a, 1'b1);
        check_eq("rdw write_first data", bus[1].dout_a, 16'h2222);
        check_eq("rdw write_first rvalid", bus[1].rvalid_a, 1'b1);
        check_eq("rdw no_change rvalid", bus[2].rvalid_a, 1'b0);
        check_eq("rdw no_change holds", bus[2].dout_a, 16'h12CD);
        read_a(4'd7);
        check_eq("after rdw read_first", bus[0].dout_a, 16'h2222);
        check_eq("after rdw write_first", bus[1].dout_a, 16'h2222);
        check_eq("after rdw no_change", bus[2].dout_a, 16'h2222);

        // Cross-port read sees the old word even in write-first mode.
        we_a = 1; be_a = 2'b11; addr_a = 4'd7; din_a = 16'h3333;
        re_b = 1; addr_b = 4'd7;
        cycle();
        clear_inputs();
        check_eq("cross read write_first", bus[1].dout_b, 16'h2222);
        check_eq("cross read read_first", bus[0].dout_b, 16'h2222);

        // Simultaneous writes to one address.
        we_a = 1; be_a = 2'b11; addr_a = 4'd9; din_a = 16'hAAAA;
        we_b = 1; be_b = 2'b11; addr_b = 4'd9; din_b = 16'h5555;
        cycle();
        clear_inputs();
        check_eq("collision full overlap", bus[0].collision, 1'b1);
        read_a(4'd9);
        check_eq("collision pulse ends", bus[0].collision, 1'b0);
        check_eq("port a priority", bus[0].dout_a, 16'hAAAA);
        we_a = 1; be_a = 2'b10; addr_a = 4'd9; din_a = 16'hAAAA;
        we_b = 1; be_b = 2'b01; addr_b = 4'd9; din_b = 16'h5555;
        cycle();
        clear_inputs();
        check_eq("disjoint lanes no collision", bus[0].collision, 1'b0);
        read_a(4'd9);
        check_eq("disjoint lane merge", bus[0].dout_a, 16'hAA55);

        // Preload 0..2 (A and B on different addresses in one cycle).
        we_a = 1; be_a = 2'b11; addr_a = 4'd0; din_a = 16'h1000;
        we_b = 1; be_b = 2'b11; addr_b = 4'd1; din_b = 16'h2001;
        cycle();
        clear_inputs();
        check_eq("different addr no collision", bus[0].collision, 1'b0);
        write_a(4'd2, 16'h3002, 2'b11);

        // Back-to-back reads, checked on both latencies.
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h2001);
        exp_q.push_back(16'h3002);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                re_a = 1; addr_a = 4'(k);
            end
            cycle();
            clear_inputs();
            check_eq($sformatf("direct rvalid k%0d", k), bus[0].rvalid_a, (k < 3) ? 1'b1 : 1'b0);
            check_eq($sformatf("outreg rvalid k%0d", k), bus[3].rvalid_a,
                     (k >= 1 && k <= 3) ? 1'b1 : 1'b0);
            if (bus[3].rvalid_a && exp_q.size() > 0) begin
                check_eq($sformatf("outreg data k%0d", k), bus[3].dout_a, exp_q.pop_front());
            end
        end
        check_eq("outreg all data seen", exp_q.size(), 0);

        // Reset with a read in flight.
        re_a = 1; addr_a = 4'd3;
        cycle();
        check_eq("pre-reset read in flight", bus[3].rvalid_a, 1'b0);
        rst_n = 0;
        #1;
        check_eq("async reset dout_a", bus[0].dout_a, 16'h0000);
        check_eq("async reset rvalid_a", bus[0].rvalid_a, 1'b0);
        check_eq("async reset outreg dout_a", bus[3].dout_a, 16'h0000);
        re_a = 1; we_a = 1; be_a = 2'b11; addr_a = 4'd3; din_a = 16'h0000;
        repeat (2) cycle();
        clear_inputs();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq($sformatf("no rvalid after reset k%0d", k), bus[0].rvalid_a | bus[3].rvalid_a, 1'b0);
        end
        read_a(4'd3);
        check_eq("contents survive reset", bus[0].dout_a, 16'hBEEF);
        cycle();
        check_eq("outreg contents survive reset", bus[3].dout_a, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
